i2s_tx_sequencer: RTL
=====================

Name: i2s_tx_sequencer

Overview:
- Drives the audio codec serial port for the drum-sound path.
- Derives BCLK and LRCLK from the system clock, fetches one stereo sample pair per frame from the sample mixer over a req/valid handshake, and serializes it in I2S format.
- Sits between the mixer and the codec pins, and replaces free-running clock dividers with a frame-aware scheduler that reports underruns.

Parameters:
- HALF_BCLK, 16, system clocks per BCLK half-period; BCLK period = 2*HALF_BCLK clk.
- BITS, 16, bits per channel word; frame = 2*BITS BCLK periods.
- Default frame length: 2*16*2*16 = 1024 clk.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- en  in  1  run enable; low = port idle
- sample_l  in  BITS  left sample, two's complement
- sample_r  in  BITS  right sample
- sample_valid  in  1  source presents sample_l/sample_r this cycle
- sample_req  out  1  sequencer requests the next stereo pair
- clr_underrun  in  1  clears the underrun flag
- bclk  out  1  serial bit clock
- lrclk  out  1  word select; 0 = left, 1 = right
- sdata  out  1  serial data, MSB first
- frame_strobe  out  1  one-cycle pulse at the start of each frame (period 0)
- underrun  out  1  sticky flag: a frame started with no fresh pair

Behaviour:
- Reset and en=0 state:
  - rst=1: bclk=lrclk=sdata=sample_req=frame_strobe=underrun=0.
  - Phase counter, bit index and shift register are cleared; holding register is marked empty.
  - en=0 (not in reset): the same idle state, except underrun keeps its value. The phase/bit counters and the holding register reset to 0/empty.
- Timing:
  - Phase counter runs 0..HALF_BCLK-1 while en=1.
  - bclk toggles on the clock where phase = HALF_BCLK-1.
  - After en rises, bclk stays low for HALF_BCLK clk, then goes high.
  - Bit period b (0..2*BITS-1) starts at a bclk falling edge (or at en rise for the first period).
  - b increments at every bclk falling edge and wraps 2*BITS-1 -> 0.
  - lrclk, sdata and frame_strobe change only at period starts, registered in the same cycle bclk falls.
- Frame format (I2S, one-bit delay):
  - lrclk = 0 for b < BITS, 1 otherwise.
  - Frame word F = {L, R}, 2*BITS bits. sdata in period b = F[2*BITS-1-(b-1)] for b >= 1.
  - sdata in period 0 = LSB of the previous frame's R (0 after reset/enable).
- Frame load at the start of each period 0:
  - If the holding register is full: F <= holding, holding -> empty.
  - Otherwise: F <= 0 and underrun <= 1. The underrun set is suppressed for the first frame after en rises.
  - frame_strobe = 1 for exactly that one cycle.
- Request handshake:
  - sample_req rises when the holding register is empty and en=1. It does not wait for a particular bit index.
  - A pair is accepted on any cycle where sample_req=1 and sample_valid=1. sample_l/sample_r are latched into holding, holding becomes full, and sample_req drops the next cycle.
  - sample_valid is ignored while sample_req=0.
- Simultaneous events:
  - Acceptance in the same cycle as a frame load: the load sees holding as empty (zeros, underrun). The accepted pair stays in holding for the next frame.
  - clr_underrun together with a new underrun event: set wins, underrun stays 1.
- en falling mid-frame: the frame is aborted immediately; outputs go to the idle state on the next cycle.
- Latency: a pair accepted during frame k is transmitted in frame k+1. Its MSB appears at period 1 of that frame, HALF_BCLK*2 clk after frame_strobe.

Test Plan:
- Reset then en=1 with default parameters:
  - bclk first rises at clk 16 and has period 32.
  - lrclk period is 1024 clk, with lrclk high for clk 512..1023 of each frame.
  - frame_strobe pulses at clk 0, 1024, 2048, ...
- Source answers the first sample_req after 3 clk with L=16'hA5C3, R=16'h0F01:
  - Frame 1 sdata, periods 1..16 = A5C3 MSB-first; periods 17..31 = first 15 bits of 0F01.
  - Period 0 of frame 2 = 1.
  - underrun stays 0.
- Source withholds sample_valid through the frame-2 boundary:
  - Frame 2 transmits all zeros and underrun=1.
  - A late pair is sent in frame 3.
  - clr_underrun clears the flag only when no new underrun occurs in the same cycle.
- sample_valid asserted exactly on the frame-load cycle:
  - Zeros are sent and underrun is set.
  - The pair appears in the following frame.
- en dropped at bit 20 of a frame:
  - Next cycle bclk=lrclk=sdata=sample_req=0.
  - Re-enabling restarts at period 0, and the first frame raises no underrun.
- rst asserted mid-frame while underrun=1: all outputs 0 on the next clock, underrun cleared.

Source files
------------

// File: rtl/i2s_tx_sequencer_if.sv
// Mixer-to-sequencer stereo sample handshake: the sequencer raises sample_req,
// the mixer answers with sample_valid plus a left/right pair in the same cycle.
interface i2s_tx_sequencer_if #(
    parameter int BITS = 16
);
    logic [BITS-1:0] sample_l;
    logic [BITS-1:0] sample_r;
    logic            sample_valid;
    logic            sample_req;

    modport master (
        output sample_l,
        output sample_r,
        output sample_valid,
        input  sample_req
    );

    modport slave (
        input  sample_l,
        input  sample_r,
        input  sample_valid,
        output sample_req
    );
endinterface

// File: rtl/i2s_tx_sequencer.sv
// Frame-aware I2S transmitter: divides clk into bclk/lrclk and serializes one stereo pair per frame.
// A pair accepted in frame k goes out in frame k+1; an empty holding register at a frame start sends zeros and sets underrun.
module i2s_tx_sequencer #(
    parameter int HALF_BCLK = 16,
    parameter int BITS      = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    i2s_tx_sequencer_if.slave mix,
    input  logic              clr_underrun,
    output logic              bclk,
    output logic              lrclk,
    output logic              sdata,
    output logic              frame_strobe,
    output logic              underrun
);

    localparam int FW = 2 * BITS;
    localparam int PW = (HALF_BCLK > 1) ? $clog2(HALF_BCLK) : 1;
    localparam int BW = $clog2(FW);

    localparam logic [PW-1:0] PH_LAST = PW'(HALF_BCLK - 1);
    localparam logic [BW-1:0] BI_LAST = BW'(FW - 1);
    localparam logic [BW-1:0] BI_RIGHT = BW'(BITS);

    typedef enum logic {
        ST_IDLE,
        ST_RUN
    } state_t;

    state_t          state_q, state_d;
    logic [PW-1:0]   phase_q, phase_d;
    logic [BW-1:0]   bidx_q, bidx_d;
    logic            bclk_q, bclk_d;
    logic            lrclk_q, lrclk_d;
    logic            sdata_q, sdata_d;
    logic            strobe_q, strobe_d;
    logic [FW-1:0]   shreg_q, shreg_d;
    logic [FW-1:0]   hold_q, hold_d;
    logic            hold_full_q, hold_full_d;
    logic            first_q, first_d;
    logic            underrun_q, underrun_d;
    logic            req_q, req_d;

    logic            phase_end;
    logic            bclk_fall;
    logic            load;
    logic            set_ur;
    logic            accept;
    logic [BW-1:0]   bnext;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            phase_q     <= '0;
            bidx_q      <= '0;
            bclk_q      <= 1'b0;
            lrclk_q     <= 1'b0;
            sdata_q     <= 1'b0;
            strobe_q    <= 1'b0;
            shreg_q     <= '0;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            first_q     <= 1'b1;
            underrun_q  <= 1'b0;
            req_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            phase_q     <= phase_d;
            bidx_q      <= bidx_d;
            bclk_q      <= bclk_d;
            lrclk_q     <= lrclk_d;
            sdata_q     <= sdata_d;
            strobe_q    <= strobe_d;
            shreg_q     <= shreg_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            first_q     <= first_d;
            underrun_q  <= underrun_d;
            req_q       <= req_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        phase_d     = phase_q;
        bidx_d      = bidx_q;
        bclk_d      = bclk_q;
        lrclk_d     = lrclk_q;
        sdata_d     = sdata_q;
        strobe_d    = 1'b0;
        shreg_d     = shreg_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        first_d     = first_q;
        underrun_d  = underrun_q;
        req_d       = 1'b0;
        load        = 1'b0;
        set_ur      = 1'b0;
        accept      = 1'b0;
        phase_end   = (phase_q == PH_LAST);
        bclk_fall   = phase_end && bclk_q;
        bnext       = (bidx_q == BI_LAST) ? '0 : bidx_q + 1'b1;

        if (!en) begin
            // Disable aborts the frame at once; underrun is the only state kept.
            state_d     = ST_IDLE;
            phase_d     = '0;
            bidx_d      = '0;
            bclk_d      = 1'b0;
            lrclk_d     = 1'b0;
            sdata_d     = 1'b0;
            shreg_d     = '0;
            hold_full_d = 1'b0;
            first_d     = 1'b1;
        end else if (state_q == ST_IDLE) begin
            state_d = ST_RUN;
            phase_d = '0;
            bidx_d  = '0;
            bclk_d  = 1'b0;
            lrclk_d = 1'b0;
            sdata_d = 1'b0;
            load    = 1'b1;
        end else begin
            if (phase_end) begin
                phase_d = '0;
                bclk_d  = ~bclk_q;
            end else begin
                phase_d = phase_q + 1'b1;
            end

            // Every bit period starts on a bclk falling edge; the shift register
            // MSB is the bit for the new period, which gives the one-bit I2S delay.
            if (bclk_fall) begin
                bidx_d  = bnext;
                lrclk_d = (bnext >= BI_RIGHT);
                sdata_d = shreg_q[FW-1];
                if (bnext == '0) begin
                    load = 1'b1;
                end else begin
                    shreg_d = shreg_q << 1;
                end
            end

            accept = req_q && mix.sample_valid;
        end

        if (load) begin
            strobe_d = 1'b1;
            first_d  = 1'b0;
            if (hold_full_q) begin
                shreg_d     = hold_q;
                hold_full_d = 1'b0;
            end else begin
                shreg_d = '0;
                set_ur  = !first_q;
            end
        end

        // A pair arriving on the load cycle misses this frame and waits in holding.
        if (accept) begin
            hold_d      = {mix.sample_l, mix.sample_r};
            hold_full_d = 1'b1;
        end

        req_d = en && !hold_full_d;

        if (set_ur) begin
            underrun_d = 1'b1;
        end else if (clr_underrun) begin
            underrun_d = 1'b0;
        end
    end

    assign bclk           = bclk_q;
    assign lrclk          = lrclk_q;
    assign sdata          = sdata_q;
    assign frame_strobe   = strobe_q;
    assign underrun       = underrun_q;
    assign mix.sample_req = req_q;

endmodule
